// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate: the driver side uses master, the gate itself uses slave.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out1_q;
  logic             valid_q;
  logic             all_ones;
  logic             any_one;
  logic [CNT_W-1:0] cnt_00;
  logic [CNT_W-1:0] cnt_01;
  logic [CNT_W-1:0] cnt_10;
  logic [CNT_W-1:0] cnt_11;

  modport master (
    output in1, in2, en, clr,
    input  out1, out1_q, valid_q, all_ones, any_one,
    input  cnt_00, cnt_01, cnt_10, cnt_11
  );

  modport slave (
    input  in1, in2, en, clr,
    output out1, out1_q, valid_q, all_ones, any_one,
    output cnt_00, cnt_01, cnt_10, cnt_11
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with combinational and registered results plus reduction flags.
// Truth-table coverage counters are built only when AND_GATE_COVER_EN is defined.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  and_gate_if.slave bus
);

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;
  logic             vld_q;

  assign res_d        = bus.in1 & bus.in2;
  assign bus.out1     = res_d;
  assign bus.all_ones = &res_d;
  assign bus.any_one  = |res_d;
  assign bus.out1_q   = res_q;
  assign bus.valid_q  = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.en;
      if (bus.en) begin
        res_q <= res_d;
      end
    end
  end

`ifdef AND_GATE_COVER_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [1:0]       sel;

  // Counter index is the {in2[0], in1[0]} pair, so cnt_01 means in1=1, in2=0.
  assign sel = {bus.in2[0], bus.in1[0]};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (bus.clr) begin
      for (int k = 0; k < 4; k++) begin
        cnt_d[k] = '0;
      end
    end else if (bus.en && (cnt_q[sel] != CNT_MAX)) begin
      cnt_d[sel] = cnt_q[sel] + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.cnt_00 = cnt_q[0];
  assign bus.cnt_01 = cnt_q[1];
  assign bus.cnt_10 = cnt_q[2];
  assign bus.cnt_11 = cnt_q[3];
`else
  logic unused_clr;

  assign unused_clr = bus.clr;
  assign bus.cnt_00 = '0;
  assign bus.cnt_01 = '0;
  assign bus.cnt_10 = '0;
  assign bus.cnt_11 = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Testbench for and_gate: vector table with a registered-result scoreboard on an 8-bit
// instance, plus hand-written truth-table, coverage, saturation and reset sequences.
module tb_and_gate;

`ifdef AND_GATE_COVER_EN
  localparam bit COV_ON = 1'b1;
`else
  localparam bit COV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] sbQ[$];
  int   modelA[4];

  always #5 clk = ~clk;

  and_gate_if #(.WIDTH(8), .CNT_W(8)) busA ();
  and_gate_if #(.WIDTH(1), .CNT_W(2)) busB ();

  and_gate #(.WIDTH(8), .CNT_W(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  and_gate #(.WIDTH(1), .CNT_W(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic       clr;
    logic [7:0] expOut;
    logic       expAll;
    logic       expAny;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cntA(input int k);
    case (k)
      0:       return busA.cnt_00;
      1:       return busA.cnt_01;
      2:       return busA.cnt_10;
      default: return busA.cnt_11;
    endcase
  endfunction

  function automatic logic [1:0] cntB(input int k);
    case (k)
      0:       return busB.cnt_00;
      1:       return busB.cnt_01;
      2:       return busB.cnt_10;
      default: return busB.cnt_11;
    endcase
  endfunction

  // Each rising edge retires one scoreboard entry when the A instance reports a load.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busA.valid_q === 1'b1) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL sb_unexpected_valid: got out1_q %h, expected no load", busA.out1_q);
      end else begin
        checkOutput("sb_out1_q", 64'(busA.out1_q), 64'(sbQ.pop_front()));
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic en, input logic clr);
    int idx;
    busA.in1 = a;
    busA.in2 = b;
    busA.en  = en;
    busA.clr = clr;
    #1;
    if (en) sbQ.push_back(a & b);
    if (clr) begin
      for (int k = 0; k < 4; k++) modelA[k] = 0;
    end else if (en) begin
      idx = {30'd0, b[0], a[0]};
      if (modelA[idx] < 255) modelA[idx]++;
    end
  endtask

  initial begin
    logic [7:0] lastQ;
    logic       bi1;
    logic       bi2;

    vecs[0]  = '{8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b1};
    vecs[1]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[3]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hA5, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[6]  = '{8'b1100xx10, 8'b10100110, 1'b1, 1'b0, 8'b10000x10, 1'b0, 1'b1};
    vecs[7]  = '{8'bxxxx1111, 8'b00001111, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1};
    vecs[8]  = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{8'h01, 8'hFF, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[10] = '{8'h03, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};

    for (int k = 0; k < 4; k++) modelA[k] = 0;
    rst_n    = 1'b0;
    busA.in1 = 8'hF0;
    busA.in2 = 8'h3C;
    busA.en  = 1'b1;
    busA.clr = 1'b0;
    busB.in1 = 1'b1;
    busB.in2 = 1'b1;
    busB.en  = 1'b1;
    busB.clr = 1'b0;

    // Reset state: registers cleared even with en high, combinational path live.
    #12;
    checkOutput("rst_out1_q", 64'(busA.out1_q), 64'h0);
    checkOutput("rst_valid_q", 64'(busA.valid_q), 64'h0);
    checkOutput("rst_out1_comb", 64'(busA.out1), 64'h30);
    checkOutput("rst_B_out1_q", 64'(busB.out1_q), 64'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rst_cntA_%0d", k), 64'(cntA(k)), 64'h0);
      checkOutput($sformatf("rst_cntB_%0d", k), 64'(cntB(k)), 64'h0);
    end

    busA.en = 1'b0;
    busB.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    lastQ = 8'h00;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].clr);
      checkOutput($sformatf("v%0d_out1", i), 64'(busA.out1), 64'(vecs[i].expOut));
      checkOutput($sformatf("v%0d_all_ones", i), 64'(busA.all_ones), 64'(vecs[i].expAll));
      checkOutput($sformatf("v%0d_any_one", i), 64'(busA.any_one), 64'(vecs[i].expAny));
      if (vecs[i].en) lastQ = vecs[i].expOut;
      tick();
      checkOutput($sformatf("v%0d_valid_q", i), 64'(busA.valid_q), 64'(vecs[i].en));
      checkOutput($sformatf("v%0d_out1_q", i), 64'(busA.out1_q), 64'(lastQ));
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("v%0d_cntA_%0d", i, k), 64'(cntA(k)),
                    64'(COV_ON ? modelA[k] : 0));
      end
    end
    busA.en  = 1'b0;
    busA.clr = 1'b0;

    // WIDTH=1 truth table on the combinational path.
    for (int i = 0; i < 4; i++) begin
      bi1 = i[0];
      bi2 = i[1];
      busB.in1 = bi1;
      busB.in2 = bi2;
      #7;
      checkOutput($sformatf("tt%0d_out1", i), 64'(busB.out1), 64'(bi1 & bi2));
      checkOutput($sformatf("tt%0d_all_ones", i), 64'(busB.all_ones), 64'(bi1 & bi2));
      checkOutput($sformatf("tt%0d_any_one", i), 64'(busB.any_one), 64'(bi1 & bi2));
    end
    tick();

    // One enabled sample of each truth-table row, then clear with en high.
    for (int i = 0; i < 4; i++) begin
      bi1 = i[0];
      bi2 = i[1];
      busB.in1 = bi1;
      busB.in2 = bi2;
      busB.en  = 1'b1;
      tick();
      checkOutput($sformatf("cov%0d_out1_q", i), 64'(busB.out1_q), 64'(bi1 & bi2));
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("cov_cntB_%0d", k), 64'(cntB(k)), 64'(COV_ON ? 1 : 0));
    end
    busB.in1 = 1'b1;
    busB.in2 = 1'b0;
    busB.clr = 1'b1;
    tick();
    checkOutput("clr_out1_q", 64'(busB.out1_q), 64'h0);
    checkOutput("clr_valid_q", 64'(busB.valid_q), 64'h1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("clr_cntB_%0d", k), 64'(cntB(k)), 64'h0);
    end

    // Two-bit counter held on the (1,1) row must stop at 3.
    busB.clr = 1'b0;
    busB.in2 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("sat_cnt_11", 64'(busB.cnt_11), 64'(COV_ON ? 3 : 0));
    checkOutput("sat_cnt_00", 64'(busB.cnt_00), 64'h0);
    checkOutput("sat_out1_q", 64'(busB.out1_q), 64'h1);

    // Asynchronous reset between edges with a load pending.
    applyStimulus(8'h3C, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_out1_q", 64'(busA.out1_q), 64'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out1_q", 64'(busA.out1_q), 64'h0);
    checkOutput("mid_rst_valid_q", 64'(busA.valid_q), 64'h0);
    checkOutput("mid_rst_out1", 64'(busA.out1), 64'h3C);
    checkOutput("mid_rst_B_cnt_11", 64'(busB.cnt_11), 64'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("mid_rst_cntA_%0d", k), 64'(cntA(k)), 64'h0);
      modelA[k] = 0;
    end
    tick();
    checkOutput("in_rst_valid_q", 64'(busA.valid_q), 64'h0);
    busA.en = 1'b0;
    busB.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h0F, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("post_rst_valid_q", 64'(busA.valid_q), 64'h1);
    checkOutput("post_rst_cnt_11", 64'(busA.cnt_11), 64'(COV_ON ? 1 : 0));
    busA.en = 1'b0;
    tick();

    checkOutput("sb_drained", 64'(sbQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/and_gate.md
# and_gate

Parameterised bitwise two-input AND unit with a zero-latency combinational output, a registered copy with load enable, reduction flags and optional truth-table coverage counters. It is a leaf primitive used wherever a gated/masked vector is needed; the combinational path gives plain AND-gate behaviour, and the clocked side gives a clean registered result for downstream logic.

## Interface
- WIDTH, 1, bit width of operands and results (1..64)
- CNT_W, 8, width of each coverage counter (2..32)
- clk  input  1  rising-edge clock for all registered state
- rst_n  input  1  asynchronous active-low reset
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out1  output  WIDTH  combinational in1 & in2
- en  input  1  load enable for registered result and coverage sampling
- clr  input  1  synchronous clear of coverage counters
- out1_q  output  WIDTH  registered in1 & in2
- valid_q  output  1  high the cycle after an enabled load
- all_ones  output  1  reduction AND of out1 (combinational)
- any_one  output  1  reduction OR of out1 (combinational)
- cnt_00, cnt_01, cnt_10, cnt_11  output  CNT_W each  counts of enabled samples by {in2[0],in1[0]}

## Operation
- out1[i] = in1[i] & in2[i] for every bit; 4-state semantics: 0 & X = 0, 1 & X = X.
- all_ones = &out1; any_one = |out1. For WIDTH=1 both equal out1.
- On rising clk with en=1: out1_q <= in1 & in2, valid_q <= 1. With en=0: out1_q holds, valid_q <= 0.
- Coverage (when compiled in): on rising clk with en=1, increment the counter selected by {in2[0],in1[0]}: 00 -> cnt_00, 01 (in1=1,in2=0) -> cnt_01, 10 (in1=0,in2=1) -> cnt_10, 11 -> cnt_11.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr=1 zeroes all four counters on the next edge; clr has priority over en for counters only (out1_q/valid_q still load if en=1).

## Timing
- out1, all_ones, any_one: zero cycles, pure combinational; settle within one propagation delay of any input change.
- out1_q, valid_q, counters: one-cycle latency from the sampling edge.
- Reset (rst_n low, asynchronous, immediate): out1_q = 0, valid_q = 0, all counters = 0. Combinational outputs are unaffected by reset.
- Reset asserted mid-operation discards any pending load; first load after release occurs on the first rising edge with rst_n=1 and en=1.
- Simultaneous clr and en: counters go to 0, increment dropped.

## Configuration
- Macro AND_GATE_COVER_EN.
- Defined: coverage counters implemented as above.
- Undefined: no counter flops; cnt_00..cnt_11 tied to 0; clr ignored; all other behaviour identical.

## Test plan
- WIDTH=1, apply (in1,in2) = (0,0),(1,0),(0,1),(1,1), wait 7 time units each -> out1 = 0,0,0,1; all_ones/any_one track out1.
- WIDTH=8, in1=8'hF0, in2=8'h3C, en=1, one edge -> out1=8'h30 immediately, out1_q=8'h30 and valid_q=1 after edge; en=0 next edge -> out1_q holds 8'h30, valid_q=0.
- AND_GATE_COVER_EN defined, four enabled cycles of the truth-table sequence -> each counter = 1; then clr with en=1 -> all counters 0 next edge, out1_q loaded.
- CNT_W=2, hold (1,1) with en=1 for 6 edges -> cnt_11 saturates at 3.
- Drive rst_n low between edges after loads -> out1_q, valid_q, counters 0 immediately, out1 still equals in1 & in2.
- Macro undefined, same coverage stimulus -> all counters read 0.
